// File: rtl/cipher_ctrl_pkg.sv
// Shared types and constants for the UART-side cipher command controller.
package cipher_ctrl_pkg;

    // Controller states; the encoding doubles as the bit position in state_led.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_TEXT  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SEND  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    // Algorithm field of the command byte; only SIMON has a core behind it.
    typedef enum logic [1:0] {
        ALGO_INIT  = 2'd0,
        ALGO_SIMON = 2'd1,
        ALGO_SHA   = 2'd2,
        ALGO_RSA   = 2'd3
    } algo_t;

    // Command byte bit positions.
    localparam int CMD_DECRYPT = 2;
    localparam int CMD_REUSE   = 3;

    // Single byte returned to the host when a command fails.
    localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/tx_byte_seq.sv
// Serialises an N-byte vector (byte 0 first) onto the UART transmitter.
//
// Transmit handshake: tx_start is a one-cycle request issued only while the
// sequencer is enabled, no byte is pending and tx_busy is low. The byte is
// pending from the tx_start cycle until the transmitter answers with a
// one-cycle tx_done; tx_data holds the pending byte for that whole window and
// reads 0 otherwise. tx_done with nothing pending is ignored. seq_done is a
// combinational pulse coinciding with the tx_done of the last byte.
module tx_byte_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [8*N-1:0] data,
    input  logic           tx_busy,
    input  logic           tx_done,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    output logic           seq_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [IW-1:0] idx;
    logic          pending;
    logic          last;

    assign last     = (idx == IDX_LAST);
    assign seq_done = en && pending && tx_done && last;

    // Issue one request per byte, advance on completion, rewind when disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            pending  <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (!en) begin
                idx     <= '0;
                pending <= 1'b0;
            end else if (pending) begin
                if (tx_done) begin
                    pending <= 1'b0;
                    idx     <= last ? '0 : idx + 1'b1;
                end
            end else if (!tx_busy) begin
                tx_start <= 1'b1;
                pending  <= 1'b1;
            end
        end
    end

    // Present the pending byte; zero when idle.
    always_comb begin
        tx_data = '0;
        if (pending) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IW'(i)) tx_data = data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/uart_cipher_ctrl.sv
// Command controller: decodes a command byte, gathers key/text bytes from the
// UART receiver, launches the cipher core and streams the result back.
module uart_cipher_ctrl
    import cipher_ctrl_pkg::*;
#(
    parameter int KEY_BYTES   = 8,
    parameter int BLK_BYTES   = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   core_start,
    output logic                   core_decrypt,
    output logic [8*KEY_BYTES-1:0] core_key,
    output logic [8*BLK_BYTES-1:0] core_text,
    input  logic [8*BLK_BYTES-1:0] core_result,
    input  logic                   core_done,
    output logic [6:0]             state_led,
    output logic                   err
);

    localparam int MAXB = (KEY_BYTES > BLK_BYTES) ? KEY_BYTES : BLK_BYTES;
    localparam int IW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC);
    localparam logic [IW-1:0] KEY_LAST = IW'(KEY_BYTES - 1);
    localparam logic [IW-1:0] BLK_LAST = IW'(BLK_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t                 state;
    state_t                 next_state;
    logic [IW-1:0]          byte_idx;
    logic [TW-1:0]          tmo_cnt;
    logic                   timed;
    logic                   tmo_hit;
    logic                   key_valid;
    logic                   decrypt_q;
    logic                   err_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [8*BLK_BYTES-1:0] text_q;
    logic [8*BLK_BYTES-1:0] result_q;
    algo_t                  cmd_algo;
    logic                   send_en;
    logic                   err_en;
    logic                   send_done;
    logic                   err_done;
    logic [7:0]             send_tx_data;
    logic [7:0]             err_tx_data;
    logic                   send_tx_start;
    logic                   err_tx_start;

    assign cmd_algo = algo_t'(rx_data[1:0]);
    assign timed    = (state == S_KEY) || (state == S_TEXT) || (state == S_WAIT);
    assign tmo_hit  = timed && (tmo_cnt == TMO_LAST);
    assign send_en  = (state == S_SEND);
    assign err_en   = (state == S_ERROR);

    // Next-state decode; a received byte or core_done beats a same-cycle timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (cmd_algo != ALGO_SIMON)  next_state = S_ERROR;
                    else if (rx_data[CMD_REUSE]) next_state = key_valid ? S_TEXT : S_ERROR;
                    else                         next_state = S_KEY;
                end
            end
            S_KEY: begin
                if (rx_valid) begin
                    if (byte_idx == KEY_LAST) next_state = S_TEXT;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                end
            end
            S_TEXT: begin
                if (rx_valid) begin
                    if (byte_idx == BLK_LAST) next_state = S_START;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                end
            end
            S_START: next_state = S_WAIT;
            S_WAIT: begin
                if (core_done)    next_state = S_SEND;
                else if (tmo_hit) next_state = S_ERROR;
            end
            S_SEND:  if (send_done) next_state = S_IDLE;
            S_ERROR: if (err_done)  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Inactivity counter: restarts on state entry and on every accepted byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (!timed || (next_state != state) ||
                     (rx_valid && (state == S_KEY || state == S_TEXT))) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Byte index into the key or text vector; rewinds on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
        end else if (next_state != state) begin
            byte_idx <= '0;
        end else if (rx_valid && (state == S_KEY || state == S_TEXT)) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    // Key and text loading; the key only becomes reusable once fully loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q     <= '0;
            text_q    <= '0;
            key_valid <= 1'b0;
        end else begin
            if (state == S_IDLE && next_state == S_KEY) key_valid <= 1'b0;
            if (state == S_KEY && rx_valid) begin
                for (int i = 0; i < KEY_BYTES; i++) begin
                    if (byte_idx == IW'(i)) key_q[8*i +: 8] <= rx_data;
                end
                if (byte_idx == KEY_LAST) key_valid <= 1'b1;
            end
            if (state == S_TEXT && rx_valid) begin
                for (int i = 0; i < BLK_BYTES; i++) begin
                    if (byte_idx == IW'(i)) text_q[8*i +: 8] <= rx_data;
                end
            end
        end
    end

    // Command latches: direction on acceptance, error flag set on ERROR entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decrypt_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && rx_valid) decrypt_q <= rx_data[CMD_DECRYPT];
            if (next_state == S_ERROR && state != S_ERROR) err_q <= 1'b1;
            else if (state == S_IDLE && rx_valid)          err_q <= 1'b0;
        end
    end

    // Capture the core result on completion while waiting for it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          result_q <= '0;
        else if (state == S_WAIT && core_done) result_q <= core_result;
    end

    tx_byte_seq #(.N(BLK_BYTES)) u_send_seq (
        .clk      (clk),
        .reset    (reset),
        .en       (send_en),
        .data     (result_q),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_data  (send_tx_data),
        .tx_start (send_tx_start),
        .seq_done (send_done)
    );

    tx_byte_seq #(.N(1)) u_err_seq (
        .clk      (clk),
        .reset    (reset),
        .en       (err_en),
        .data     (ERR_BYTE),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_data  (err_tx_data),
        .tx_start (err_tx_start),
        .seq_done (err_done)
    );

    // Only one sequencer is enabled at a time and an idle one outputs zeros.
    assign tx_data      = send_tx_data | err_tx_data;
    assign tx_start     = send_tx_start | err_tx_start;
    assign core_start   = (state == S_START);
    assign core_decrypt = decrypt_q;
    assign core_key     = key_q;
    assign core_text    = text_q;
    assign err          = err_q;

    // One-hot state indicator, bit 0 = IDLE through bit 6 = ERROR.
    always_comb begin
        state_led = '0;
        case (state)
            S_IDLE:  state_led = 7'b0000001;
            S_KEY:   state_led = 7'b0000010;
            S_TEXT:  state_led = 7'b0000100;
            S_START: state_led = 7'b0001000;
            S_WAIT:  state_led = 7'b0010000;
            S_SEND:  state_led = 7'b0100000;
            S_ERROR: state_led = 7'b1000000;
            default: state_led = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_cipher_ctrl.sv
// Bench for uart_cipher_ctrl: table of command transactions plus hand-written
// busy-hold, timeout and mid-send reset sequences, with a transmitter model.
module tb_uart_cipher_ctrl;

    localparam logic [6:0] LED_IDLE  = 7'b0000001;
    localparam logic [6:0] LED_KEY   = 7'b0000010;
    localparam logic [6:0] LED_TEXT  = 7'b0000100;
    localparam logic [6:0] LED_START = 7'b0001000;
    localparam logic [6:0] LED_WAIT  = 7'b0010000;
    localparam logic [6:0] LED_SEND  = 7'b0100000;
    localparam logic [6:0] LED_ERR   = 7'b1000000;

    typedef struct {
        logic [7:0]  cmd;
        logic        send_key;
        logic [63:0] key;
        logic [31:0] text;
        logic [31:0] result;
        logic        exp_err;
        logic        exp_dec;
        logic [63:0] exp_key;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] core_key;
    logic [31:0] core_text;
    logic [31:0] core_result;
    logic        core_done;
    logic [6:0]  state_led;
    logic        err;

    logic model_busy, model_done, force_busy, spur_done;
    int   total = 0;
    int   bad   = 0;
    int   tx_cnt = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[8];

    assign tx_busy = model_busy | force_busy;
    assign tx_done = model_done | spur_done;

    uart_cipher_ctrl #(.KEY_BYTES(8), .BLK_BYTES(4), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .core_start   (core_start),
        .core_decrypt (core_decrypt),
        .core_key     (core_key),
        .core_text    (core_text),
        .core_result  (core_result),
        .core_done    (core_done),
        .state_led    (state_led),
        .err          (err)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog: stops a hung run with a report.
    initial begin
        #300000;
        $display("FAIL watchdog act=running exp=finished");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: pops the scoreboard on each tx_start, stays busy
    // three cycles checking tx_data is held, then pulses tx_done.
    initial begin
        logic [7:0] e, cur;
        logic aborted;
        model_busy = 1'b0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (reset && tx_start) begin
                tx_cnt++;
                chk("tx_start_while_busy", tx_busy, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected act=%0h exp=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", tx_data, e);
                end
                cur = tx_data;
                model_busy = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("tx_hold", tx_data, cur);
                    if (k == 0) chk("tx_start_pulse", tx_start, 0);
                end
                model_busy = 1'b0;
                if (!aborted) model_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((state_led != LED_IDLE || exp_q.size() != 0 || model_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", state_led, LED_IDLE);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // mode 0: normal, 1: hold tx_busy in SEND, 2: reset during second byte.
    task automatic run_txn(input vec_t v, input int mode);
        int base, n, starts;
        send_byte(v.cmd);
        if (v.exp_err) begin
            chk("cmd_state_err", state_led, LED_ERR);
            chk("err_set", err, 1);
            exp_q.push_back(8'hEE);
            wait_idle();
            return;
        end
        chk("cmd_state", state_led, v.send_key ? LED_KEY : LED_TEXT);
        chk("err_clear", err, 0);
        chk("decrypt_latch", core_decrypt, v.exp_dec);
        if (v.send_key) begin
            for (int i = 0; i < 8; i++) begin
                gap();
                send_byte(v.key[8*i +: 8]);
            end
            chk("key_to_text", state_led, LED_TEXT);
        end
        for (int i = 0; i < 4; i++) begin
            gap();
            send_byte(v.text[8*i +: 8]);
        end
        chk("core_start_on", core_start, 1);
        chk("start_state", state_led, LED_START);
        chk("core_key", core_key, v.exp_key);
        chk("core_text", core_text, v.text);
        chk("decrypt_held", core_decrypt, v.exp_dec);
        @(negedge clk);
        chk("core_start_off", core_start, 0);
        chk("wait_state", state_led, LED_WAIT);
        gap();
        if (mode == 1) force_busy = 1'b1;
        base = tx_cnt;
        @(negedge clk);
        core_result = v.result;
        core_done   = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(v.result[8*i +: 8]);
        @(negedge clk);
        core_done   = 1'b0;
        core_result = $urandom;
        chk("send_state", state_led, LED_SEND);
        if (mode == 0) begin
            @(negedge clk);
            chk("first_tx_latency", tx_start, 1);
        end else if (mode == 1) begin
            starts = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (tx_start) starts++;
                spur_done = (k == 20);
            end
            spur_done = 1'b0;
            chk("busy_hold_starts", starts, 0);
            chk("busy_hold_state", state_led, LED_SEND);
            force_busy = 1'b0;
        end else begin
            n = 0;
            while (tx_cnt < base + 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_byte2", tx_cnt, base + 2);
            #2;
            reset = 1'b0;
            #1;
            chk("rst_state_led", state_led, LED_IDLE);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_core_start", core_start, 0);
            chk("rst_core_decrypt", core_decrypt, 0);
            chk("rst_core_key", core_key, 0);
            chk("rst_core_text", core_text, 0);
            chk("rst_err", err, 0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            exp_q.delete();
            @(negedge clk);
            return;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        vec_t v;
        reset       = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        core_result = '0;
        core_done   = 1'b0;
        force_busy  = 1'b0;
        spur_done   = 1'b0;

        vecs[0] = '{8'h08, 1'b0, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0};
        vecs[1] = '{8'h03, 1'b0, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0};
        vecs[2] = '{8'h01, 1'b1, 64'h0706050403020100, 32'hDDCCBBAA, 32'h44332211,
                    1'b0, 1'b0, 64'h0706050403020100};
        vecs[3] = '{8'h0D, 1'b0, 64'h0, 32'h78563412, 32'h0DF0FECA,
                    1'b0, 1'b1, 64'h0706050403020100};
        vecs[4] = '{8'h05, 1'b1, 64'h8877665544332211, 32'h5A5AA5A5, 32'h9C3E7F01,
                    1'b0, 1'b1, 64'h8877665544332211};
        vecs[5] = '{8'h00, 1'b0, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0};
        vecs[6] = '{8'hF9, 1'b0, 64'h0, 32'hC0DEFACE, 32'h600DF00D,
                    1'b0, 1'b0, 64'h8877665544332211};
        vecs[7] = '{8'h0A, 1'b0, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_state_led", state_led, LED_IDLE);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_core_start", core_start, 0);
        chk("reset_core_decrypt", core_decrypt, 0);
        chk("reset_core_key", core_key, 0);
        chk("reset_core_text", core_text, 0);
        chk("reset_err", err, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table of transactions.
        for (int i = 0; i < 8; i++) run_txn(vecs[i], 0);

        // tx_busy held high for 50 cycles with a spurious tx_done.
        v = '{8'h0D, 1'b0, 64'h0, 32'h13572468, 32'hA1B2C3D4, 1'b0, 1'b1, 64'h8877665544332211};
        run_txn(v, 1);

        // Inactivity timeout after three key bytes.
        send_byte(8'h01);
        chk("tmo_key_state", state_led, LED_KEY);
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1));
        exp_q.push_back(8'hEE);
        n = 0;
        while (state_led != LED_ERR && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", err, 1);
        wait_idle();
        v = '{8'h09, 1'b0, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0};
        run_txn(v, 0);

        // Reset during the second result byte, then a clean transaction.
        v = '{8'h05, 1'b1, 64'hF0E1D2C3B4A59687, 32'h0BADBEEF, 32'h55AA33CC,
              1'b0, 1'b1, 64'hF0E1D2C3B4A59687};
        run_txn(v, 2);
        v = '{8'h01, 1'b1, 64'h0123456789ABCDEF, 32'hFEEDC0DE, 32'h31415926,
              1'b0, 1'b0, 64'h0123456789ABCDEF};
        run_txn(v, 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
